adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 151 +++++++++++++++
 tb/tb_adc_capture.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Armed, triggered capture of one ADC channel into an inferred block RAM.
// The read port is registered and returns old contents on a same-address write.
module adc_capture #(
  parameter int WIDTH = 8,
  parameter int PORTS = 4,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adc_valid,
  input  logic [PORTS*WIDTH-1:0] adc_data,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   sw_trig,
  input  logic                   trig_en,
  input  logic [7:0]             chan_sel,
  input  logic [WIDTH-1:0]       threshold,
  input  logic [AW:0]            length,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [1:0]             state,
  output logic [AW:0]            count,
  output logic                   done
);

  localparam int CW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [AW:0]             count_reg;
  logic [AW:0]             len_reg;
  logic [CW-1:0]           chan_reg;
  logic                    done_reg;
  logic signed [WIDTH-1:0] prev_reg;
  logic                    have_prev_reg;
  logic [WIDTH-1:0]        rd_data_reg;
  logic                    rd_valid_reg;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic [WIDTH-1:0] chan_data [PORTS];

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_chan
      assign chan_data[gi] = adc_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] thr;
  logic                    level_hit;
  logic                    trigger;
  logic                    wr_en;
  logic [AW:0]             count_next;
  logic [AW:0]             len_eff;
  logic [CW-1:0]           chan_eff;

  assign cur        = chan_data[chan_reg];
  assign thr        = threshold;
  // A level crossing needs a previous sample seen while armed.
  assign level_hit  = trig_en && adc_valid && have_prev_reg && (prev_reg < thr) && (cur >= thr);
  assign trigger    = (state_reg == ARMED) && (sw_trig || level_hit);
  assign wr_en      = !rst && !abort && adc_valid && (trigger || state_reg == CAPTURE);
  assign count_next = count_reg + 1'b1;
  assign len_eff    = (length == '0 || length > FULL_LEN) ? FULL_LEN : length;
  assign chan_eff   = (int'(chan_sel) < PORTS) ? CW'(chan_sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      done_reg      <= 1'b0;
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
      len_reg       <= FULL_LEN;
      chan_reg      <= '0;
    end else if (abort) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (arm) begin
            state_reg     <= ARMED;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            len_reg       <= len_eff;
            chan_reg      <= chan_eff;
            have_prev_reg <= 1'b0;
          end
        end
        ARMED: begin
          if (adc_valid) begin
            prev_reg      <= cur;
            have_prev_reg <= 1'b1;
          end
          if (trigger) begin
            // count is zero here, so a valid trigger sample lands at address 0.
            if (adc_valid && count_next == len_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= CAPTURE;
            end
            if (adc_valid) count_reg <= count_next;
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            count_reg <= count_next;
            if (count_next == len_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count_reg[AW-1:0]] <= cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= mem[rd_addr];
    end
  end

  assign state    = state_reg;
  assign count    = count_reg;
  assign done     = done_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: directed scenarios plus a randomized
// run, all compared against a behavioural capture model kept in the bench.
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid;
  logic [31:0] adc_data;
  logic        arm;
  logic        abort;
  logic        sw_trig;
  logic        trig_en;
  logic [7:0]  chan_sel;
  logic [7:0]  threshold;
  logic [10:0] length;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic [10:0] count;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int       m_state = 0;
  int       m_count = 0;
  int       m_len   = 1024;
  int       m_chan  = 0;
  int       m_prev  = 0;
  bit       m_have_prev = 0;
  bit       m_done  = 0;
  logic [7:0] m_mem [1024];
  bit       m_known [1024];
  logic [7:0] m_rd_data = 8'd0;
  bit       m_rd_valid = 0;
  bit       m_rd_known = 0;

  adc_capture dut (
    .clk       (clk),
    .rst       (rst),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .arm       (arm),
    .abort     (abort),
    .sw_trig   (sw_trig),
    .trig_en   (trig_en),
    .chan_sel  (chan_sel),
    .threshold (threshold),
    .length    (length),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .state     (state),
    .count     (count),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sval(input int c);
    logic signed [7:0] s;
    s = adc_data[c*8 +: 8];
    return int'(s);
  endfunction

  function automatic int thr_val();
    logic signed [7:0] s;
    s = threshold;
    return int'(s);
  endfunction

  task automatic set_ch(input int c0, input int c1, input int c2, input int c3);
    adc_data = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endtask

  task automatic idle_inputs();
    adc_valid = 0; arm = 0; abort = 0; sw_trig = 0; trig_en = 0;
    rd_en = 0; rd_addr = '0;
  endtask

  task automatic model_store(input int v);
    m_mem[m_count]   = 8'(v);
    m_known[m_count] = 1;
    m_count++;
    if (m_count == m_len) begin
      m_state = 3;
      m_done  = 1;
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sampled, then
  // outputs are observed 1 time unit after the edge.
  task automatic step();
    int cur, thr;
    bit trig;
    @(posedge clk);
    cur = sval(m_chan);
    thr = thr_val();
    if (rst) begin
      m_rd_valid = 0; m_rd_data = 8'd0; m_rd_known = 1;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) begin
        m_rd_data  = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
      end
    end
    if (rst) begin
      m_state = 0; m_count = 0; m_done = 0; m_prev = 0; m_have_prev = 0;
    end else if (abort) begin
      m_state = 0; m_done = 0;
    end else if ((m_state == 0 || m_state == 3) && arm) begin
      m_state = 1; m_count = 0; m_done = 0; m_have_prev = 0;
      m_len  = (length == 0 || length > 1024) ? 1024 : int'(length);
      m_chan = (chan_sel >= 4) ? 0 : int'(chan_sel);
    end else if (m_state == 1) begin
      trig = sw_trig || (trig_en && adc_valid && m_have_prev && m_prev < thr && cur >= thr);
      if (adc_valid) begin m_prev = cur; m_have_prev = 1; end
      if (trig) begin
        m_state = 2;
        if (adc_valid) model_store(cur);
      end
    end else if (m_state == 2 && adc_valid) begin
      model_store(cur);
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; arm = 1; sw_trig = 1; adc_valid = 1; rd_en = 1; adc_data = 32'h0a0b0c0d;
    length = 11'd4; chan_sel = 8'd0; threshold = 8'd0;
    step(); step();
    rst = 0; idle_inputs();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    $display("test_reset: state=%0d count=%0d done=%0b", state, count, done);
  endtask

  task automatic test_sw_trigger();
    idle_inputs();
    arm = 1; length = 11'd4; chan_sel = 8'd0;
    step(); arm = 0;
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL swtrig_armed: got %0d expected 1", state); end
    adc_valid = 1; sw_trig = 1;
    for (int v = 10; v <= 14; v++) begin
      set_ch(v, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      step(); sw_trig = 0;
    end
    adc_valid = 0;
    n_checks++; if (count !== 11'd4) begin n_fail++; $display("FAIL swtrig_count: got %0d expected 4", count); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL swtrig_done: got %0b expected 1", done); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL swtrig_state: got %0d expected 3", state); end
    $display("test_sw_trigger: state=%0d count=%0d done=%0b", state, count, done);
  endtask

  task automatic test_read();
    idle_inputs();
    rd_en = 1; rd_addr = 10'd1;
    step(); rd_en = 0;
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid: got %0b expected 1", rd_valid); end
    n_checks++; if (rd_data !== 8'd11) begin n_fail++; $display("FAIL read_addr1: got %0d expected 11", rd_data); end
    step();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_drop: got %0b expected 0", rd_valid); end
    for (int a = 0; a < 4; a++) begin
      rd_en = 1; rd_addr = 10'(a);
      step(); rd_en = 0;
      n_checks++; if (rd_data !== 8'(10 + a)) begin n_fail++; $display("FAIL read_mem%0d: got %0d expected %0d", a, rd_data, 10 + a); end
      $display("test_read: addr=%0d data=%0d valid=%0b", a, rd_data, rd_valid);
    end
  endtask

  task automatic test_level_trigger();
    int seq [4] = '{-5, -1, 0, 3};
    int exp_state [4] = '{1, 1, 2, 2};
    idle_inputs();
    arm = 1; length = 11'd4; chan_sel = 8'd1;
    step(); arm = 0;
    trig_en = 1; threshold = 8'd0; adc_valid = 1;
    for (int i = 0; i < 4; i++) begin
      set_ch($urandom_range(0, 255), seq[i], $urandom_range(0, 255), $urandom_range(0, 255));
      step();
      n_checks++; if (state !== 2'(exp_state[i])) begin n_fail++; $display("FAIL level_state s%0d: got %0d expected %0d", i, state, exp_state[i]); end
      $display("test_level_trigger: sample=%0d state=%0d count=%0d", seq[i], state, count);
    end
    n_checks++; if (count !== 11'd2) begin n_fail++; $display("FAIL level_count: got %0d expected 2", count); end
    adc_valid = 0; rd_en = 1; rd_addr = 10'd0;
    step(); rd_en = 0;
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL level_mem0: got %0d expected 0", rd_data); end
    // First valid sample after arm may not fire even though it is above threshold.
    abort = 1; step(); abort = 0;
    arm = 1; step(); arm = 0;
    threshold = 8'd3; adc_valid = 1;
    set_ch(0, 5, 0, 0); step();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL level_first_sample: got %0d expected 1", state); end
    set_ch(0, 1, 0, 0); step();
    set_ch(0, 4, 0, 0); step();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL level_retrigger: got %0d expected 2", state); end
    $display("test_level_trigger: rearm state=%0d count=%0d", state, count);
    idle_inputs(); abort = 1; step(); abort = 0;
  endtask

  task automatic test_full_depth();
    int cap_cycles = 0;
    bit reached = 0;
    idle_inputs();
    arm = 1; length = 11'd0; chan_sel = 8'd2;
    step(); arm = 0;
    sw_trig = 1; step(); sw_trig = 0;
    n_checks++; if (state !== 2'd2 || count !== 11'd0) begin n_fail++; $display("FAIL depth_trig_novalid: got state %0d count %0d expected 2/0", state, count); end
    adc_valid = 1;
    for (int i = 0; i < 1100 && !reached; i++) begin
      adc_data = $urandom;
      step();
      cap_cycles++;
      n_checks++; if (count !== 11'(m_count) || state !== 2'(m_state)) begin n_fail++; $display("FAIL depth_cycle %0d: got count %0d state %0d expected %0d/%0d", i, count, state, m_count, m_state); end
      if (m_state == 3) reached = 1;
    end
    adc_valid = 0;
    n_checks++; if (!reached || cap_cycles != 1024) begin n_fail++; $display("FAIL depth_done_timing: got %0d writes reached=%0b expected 1024", cap_cycles, reached); end
    n_checks++; if (count !== 11'd1024 || state !== 2'd3 || done !== 1'b1) begin n_fail++; $display("FAIL depth_final: got count %0d state %0d done %0b expected 1024/3/1", count, state, done); end
    $display("test_full_depth: writes=%0d count=%0d state=%0d", cap_cycles, count, state);
  endtask

  task automatic test_toggle_valid();
    int exp_state [5] = '{2, 2, 2, 2, 3};
    int exp_count [5] = '{1, 1, 2, 2, 3};
    idle_inputs();
    arm = 1; length = 11'd3; chan_sel = 8'd3;
    step(); arm = 0;
    sw_trig = 1;
    for (int i = 0; i < 5; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data = $urandom;
      step(); sw_trig = 0;
      n_checks++; if (state !== 2'(exp_state[i]) || count !== 11'(exp_count[i])) begin n_fail++; $display("FAIL toggle_c%0d: got state %0d count %0d expected %0d/%0d", i, state, count, exp_state[i], exp_count[i]); end
      $display("test_toggle_valid: cycle=%0d valid=%0b state=%0d count=%0d", i, adc_valid, state, count);
    end
    adc_valid = 0;
  endtask

  task automatic test_abort_reset();
    idle_inputs();
    arm = 1; length = 11'd8; chan_sel = 8'd0;
    step(); arm = 0;
    adc_valid = 1; sw_trig = 1; adc_data = $urandom; step(); sw_trig = 0;
    adc_data = $urandom; step(); adc_valid = 0;
    abort = 1; arm = 1; step(); abort = 0; arm = 0;
    n_checks++; if (state !== 2'd0 || count !== 11'd2 || done !== 1'b0) begin n_fail++; $display("FAIL abort: got state %0d count %0d done %0b expected 0/2/0", state, count, done); end
    $display("test_abort_reset: abort state=%0d count=%0d", state, count);
    arm = 1; step(); arm = 0;
    adc_valid = 1; sw_trig = 1;
    for (int i = 0; i < 3; i++) begin adc_data = $urandom; step(); sw_trig = 0; end
    rst = 1; arm = 1; abort = 0; step(); rst = 0; arm = 0; adc_valid = 0;
    n_checks++; if (state !== 2'd0 || count !== 11'd0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got state %0d count %0d done %0b expected 0/0/0", state, count, done); end
    $display("test_abort_reset: reset state=%0d count=%0d", state, count);
  endtask

  task automatic test_chan_oob();
    int c0;
    idle_inputs();
    arm = 1; length = 11'd2; chan_sel = 8'd7;
    step(); arm = 0;
    c0 = $urandom_range(0, 255);
    adc_valid = 1; sw_trig = 1;
    set_ch(c0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    step(); sw_trig = 0;
    adc_data = $urandom; step(); adc_valid = 0;
    rd_en = 1; rd_addr = 10'd0; step(); rd_en = 0;
    n_checks++; if (rd_data !== 8'(c0)) begin n_fail++; $display("FAIL chan_oob: got %0d expected %0d", rd_data, c0); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL chan_oob_state: got %0d expected 3", state); end
    $display("test_chan_oob: mem0=%0d state=%0d", rd_data, state);
  endtask

  task automatic test_random();
    int lens [8] = '{0, 1, 2, 3, 5, 16, 1500, 7};
    int nerr0 = n_fail;
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      arm       = ($urandom_range(0, 19) == 0);
      sw_trig   = ($urandom_range(0, 39) == 0);
      trig_en   = $urandom_range(0, 1);
      adc_valid = ($urandom_range(0, 9) < 7);
      adc_data  = $urandom;
      threshold = 8'($urandom_range(0, 255));
      chan_sel  = 8'($urandom_range(0, 9));
      length    = 11'(lens[$urandom_range(0, 7)]);
      rd_en     = $urandom_range(0, 1);
      rd_addr   = 10'($urandom_range(0, 15));
      step();
      n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state c%0d: got %0d expected %0d", i, state, m_state); end
      n_checks++; if (count !== 11'(m_count)) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", i, count, m_count); end
      n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %0b expected %0b", i, done, m_done); end
      n_checks++; if (rd_valid !== m_rd_valid) begin n_fail++; $display("FAIL rnd_rd_valid c%0d: got %0b expected %0b", i, rd_valid, m_rd_valid); end
      if (m_rd_valid && m_rd_known) begin
        n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL rnd_rd_data c%0d: got %0d expected %0d", i, rd_data, m_rd_data); end
      end
    end
    rst = 0; idle_inputs();
    $display("test_random: 3000 cycles, new failures=%0d", n_fail - nerr0);
  endtask

  initial begin
    idle_inputs();
    rst = 1; adc_data = '0; chan_sel = '0; threshold = '0; length = '0;
    test_reset();
    test_sw_trigger();
    test_read();
    test_level_trigger();
    test_full_depth();
    test_toggle_valid();
    test_abort_reset();
    test_chan_oob();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
